// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: on-chip trace capture for the pipelined MIPS CPU.
// Records {pc, instr, alu_result, jump_flag, stall} every cycle into a
// circular buffer once armed. A trigger (jump, stall or PC match, selected by
// trig_mask) starts POST_TRIG further captures, after which the buffer freezes
// and is drained oldest-first over a valid/ready stream.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   arm                   start capture (IDLE only)
//   clear                 synchronous abort to IDLE from any state
//   trig_mask, trig_pc    trigger selection and PC compare value
//   pc, instr, alu_result,
//   jump_flag, stall      sampled pipeline observables
//   out_valid, out_ready,
//   out_data, out_last    trace readout stream
//   busy                  capturing (ARMED or POST)
//   triggered             trigger seen since the last arm
//   trig_index            readout position of the trigger entry
module pipe_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  clear,
    input  logic [2:0]            trig_mask,
    input  logic [DATA_W-1:0]     trig_pc,
    input  logic [DATA_W-1:0]     pc,
    input  logic [DATA_W-1:0]     instr,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [2:0]            jump_flag,
    input  logic                  stall,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*DATA_W+3:0]   out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  triggered,
    output logic [ADDR_W-1:0]     trig_index
);

    localparam int ENTRY_W = 3*DATA_W + 4;
    localparam int CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DUMP} state_t;

    state_t               state_q;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr_q;
    logic [ADDR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     remain_q;
    logic [CNT_W-1:0]     post_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic                 triggered_q;
    logic [ADDR_W-1:0]    trig_index_q;

    logic [ENTRY_W-1:0]   sample;
    logic                 trig_hit;
    logic                 capture;
    logic                 dump_now;
    logic [ADDR_W-1:0]    wr_ptr_d;
    logic [CNT_W-1:0]     count_d;
    logic [CNT_W-1:0]     tidx_d;

    assign sample   = {pc, instr, alu_result, jump_flag, stall};
    assign trig_hit = (trig_mask[0] & (|jump_flag))
                    | (trig_mask[1] & stall)
                    | (trig_mask[2] & (pc == trig_pc));
    assign capture  = !clear && ((state_q == S_ARMED) || (state_q == S_POST));

    // Post-write pointer/count: DUMP setup uses these so the entry written on
    // the transition edge is included.
    assign wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    assign count_d  = (count_q == DEPTH_C) ? count_q : count_q + ONE_C;
    assign tidx_d   = count_d - ONE_C - POST_C;

    // Freeze after the trigger entry plus POST_TRIG more; with POST_TRIG==0
    // the trigger entry itself is the last one.
    assign dump_now = !clear
                   && (((state_q == S_ARMED) && trig_hit && (POST_TRIG == 0))
                    || ((state_q == S_POST) && (post_q == ONE_C)));

    always_ff @(posedge clk) begin
        if (capture) begin
            mem_q[wr_ptr_q] <= sample;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            remain_q     <= '0;
            post_q       <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            triggered_q  <= 1'b0;
            trig_index_q <= '0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        wr_ptr_q    <= '0;
                        count_q     <= '0;
                        post_q      <= '0;
                        triggered_q <= 1'b0;
                        state_q     <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    wr_ptr_q <= wr_ptr_d;
                    count_q  <= count_d;
                    if (trig_hit) begin
                        triggered_q <= 1'b1;
                        post_q      <= POST_C;
                        state_q     <= S_POST;
                    end
                end
                S_POST: begin
                    wr_ptr_q <= wr_ptr_d;
                    count_q  <= count_d;
                    post_q   <= post_q - ONE_C;
                end
                S_DUMP: begin
                    if (out_ready) begin
                        rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                        remain_q   <= remain_q - ONE_C;
                        out_last_q <= (remain_q == CNT_W'(2));
                        if (remain_q == ONE_C) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (dump_now) begin
                // Oldest entry sits count_d slots behind the next write slot;
                // a full buffer (count_d == DEPTH) wraps to wr_ptr_d itself.
                rd_ptr_q     <= wr_ptr_d - count_d[ADDR_W-1:0];
                trig_index_q <= tidx_d[ADDR_W-1:0];
                remain_q     <= count_d;
                out_valid_q  <= 1'b1;
                out_last_q   <= (count_d == ONE_C);
                state_q      <= S_DUMP;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_data   = out_valid_q ? mem_q[rd_ptr_q] : '0;
    assign busy       = (state_q == S_ARMED) || (state_q == S_POST);
    assign triggered  = triggered_q;
    assign trig_index = trig_index_q;

endmodule
